// File: rtl/grid_pkg.sv
// Shared types and constants for the 8x8 Life grid path.
package grid_pkg;

  localparam int unsigned GRID_W   = 64;
  localparam int unsigned ROW_W    = 8;
  localparam int unsigned NUM_ROWS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } tx_state_t;

endpackage

// File: rtl/grid_baud_gen.sv
// Bit-period timer: pulses tick on the last cycle of each serial bit.
module grid_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count cycles within a bit; parked at 0 while disabled so each frame starts aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/grid_uart_tx.sv
// Sends a latched 64-bit grid snapshot as eight 8N1 frames, row 0 first.
module grid_uart_tx
  import grid_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [GRID_W-1:0] grid,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [2:0]        row_idx
);

  localparam int unsigned ROWC_W = $clog2(NUM_ROWS);
  localparam int unsigned BITC_W = $clog2(ROW_W);
  localparam logic [ROWC_W-1:0] ROW_LAST = ROWC_W'(NUM_ROWS - 1);
  localparam logic [BITC_W-1:0] BIT_LAST = BITC_W'(ROW_W - 1);

  tx_state_t         r_state, w_state_next;
  logic [GRID_W-1:0] r_shadow, w_shadow_next;
  logic [ROWC_W-1:0] r_row, w_row_next;
  logic [BITC_W-1:0] r_bit, w_bit_next;
  logic              r_tx, r_busy, r_done;
  logic              w_tx_next, w_busy_next, w_done_next;
  logic              w_tick;

  grid_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .en   (r_state != IDLE),
    .tick (w_tick)
  );

  // State, shadow grid and row/bit counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_row    <= '0;
      r_bit    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_shadow <= w_shadow_next;
      r_row    <= w_row_next;
      r_bit    <= w_bit_next;
    end
  end

  // Next-state and counter update logic; transitions happen only on bit ticks.
  always_comb begin
    w_state_next  = r_state;
    w_shadow_next = r_shadow;
    w_row_next    = r_row;
    w_bit_next    = r_bit;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next  = START_BIT;
          w_shadow_next = grid;
          w_row_next    = '0;
          w_bit_next    = '0;
        end
      end
      START_BIT: begin
        if (w_tick) w_state_next = DATA_BITS;
      end
      DATA_BITS: begin
        if (w_tick) begin
          w_bit_next = r_bit + 1'b1;
          if (r_bit == BIT_LAST) w_state_next = STOP_BIT;
        end
      end
      STOP_BIT: begin
        if (w_tick) begin
          if (r_row == ROW_LAST) begin
            w_state_next = IDLE;
            w_row_next   = '0;
          end else begin
            w_state_next = START_BIT;
            w_row_next   = r_row + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from next state so tx is registered glitch-free.
  always_comb begin
    w_tx_next   = 1'b1;
    w_busy_next = (w_state_next != IDLE);
    w_done_next = (r_state == STOP_BIT) && w_tick && (r_row == ROW_LAST);
    case (w_state_next)
      START_BIT: w_tx_next = 1'b0;
      DATA_BITS: w_tx_next = r_shadow[{w_row_next, w_bit_next}];
      default:   w_tx_next = 1'b1;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_tx   <= w_tx_next;
      r_busy <= w_busy_next;
      r_done <= w_done_next;
    end
  end

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign done    = r_done;
  assign row_idx = r_row;

endmodule

// File: tb/tb_grid_uart_tx.sv
// Scoreboard bench for grid_uart_tx: a UART receiver decodes tx and checks bytes and done timing.
module tb_grid_uart_tx;

  localparam int unsigned C    = 4;
  localparam time         TCLK = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [63:0] grid = '0;
  logic        tx, busy, done;
  logic [2:0]  row_idx;

  always #5 clk = ~clk;

  grid_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .grid   (grid),
    .tx     (tx),
    .busy   (busy),
    .done   (done),
    .row_idx(row_idx)
  );

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_bytes[$];
  time         exp_done[$];
  time         next_free = 0;
  int          epoch = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference model: a start is honoured only if the transmitter is idle; a transfer
  // is eight rows of the latched grid and the line is free again 80*C+1 edges later.
  task automatic step(input logic s, input logic [63:0] g);
    @(negedge clk);
    start = s;
    grid  = g;
    @(posedge clk);
    if (s && !reset && $time >= next_free) begin
      for (int r = 0; r < 8; r++) exp_bytes.push_back(g[8*r +: 8]);
      exp_done.push_back($time + 80 * C * TCLK);
      next_free = $time + (80 * C + 1) * TCLK;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && $time < next_free + 20 * TCLK; i++) step(1'b0, rnd64());
  endtask

  // Receiver: detect falling edge, sample at mid-bit, compare each byte to the scoreboard.
  initial begin
    logic       prev;
    logic [7:0] b;
    logic       sb;
    int         ep;
    prev = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (prev && !tx) begin
        ep = epoch;
        repeat (C / 2) @(posedge clk);
        #1;
        sb = tx;
        if (ep == epoch) check(sb == 1'b0, "start_bit", sb, 0);
        for (int k = 0; k < 8; k++) begin
          repeat (C) @(posedge clk);
          #1;
          b[k] = tx;
        end
        repeat (C) @(posedge clk);
        #1;
        sb = tx;
        if (ep == epoch) begin
          check(sb == 1'b1, "stop_bit", sb, 1);
          if (exp_bytes.size() == 0) check(1'b0, "unexpected_byte", b, 0);
          else begin
            logic [7:0] e;
            e = exp_bytes.pop_front();
            check(b == e, "row_byte", b, e);
          end
        end
        prev = 1'b1;
      end else begin
        prev = tx;
      end
    end
  end

  // Handshake monitor: done timing, busy length, back-to-back restart.
  initial begin
    logic prev_done, prev_busy, s_edge;
    time  busy_rise;
    prev_done = 1'b0;
    prev_busy = 1'b0;
    busy_rise = 0;
    forever begin
      @(posedge clk);
      s_edge = start;
      #1;
      if (!reset) begin
        if (prev_done && s_edge) begin
          check(tx == 1'b0, "b2b_tx", tx, 0);
          check(busy == 1'b1, "b2b_busy", busy, 1);
        end
        if (busy && !prev_busy) busy_rise = $time - 1;
        if (done) begin
          check(busy == 1'b0, "busy_at_done", busy, 0);
          check(($time - 1 - busy_rise) == 80 * C * TCLK, "busy_len", $time - 1 - busy_rise, 80 * C * TCLK);
          if (exp_done.size() == 0) check(1'b0, "unexpected_done", $time - 1, 0);
          else begin
            time e;
            e = exp_done.pop_front();
            check(($time - 1) == e, "done_time", $time - 1, e);
          end
        end
      end
      prev_done = done;
      prev_busy = busy;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset before any clock edge.
    #1 reset = 1'b1;
    #1;
    check(tx == 1'b1, "rst_tx", tx, 1);
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(done == 1'b0, "rst_done", done, 0);
    check(row_idx == 3'd0, "rst_row", row_idx, 0);
    @(negedge clk) reset = 1'b0;
    repeat (3) step(1'b0, '0);

    // Known grid; ignored all-ones start at cycle 100; grid noise every cycle.
    step(1'b1, 64'h0412_6424_0034_3C28);
    for (int i = 1; i < 330; i++)
      step(i == 100, (i == 100) ? 64'hFFFF_FFFF_FFFF_FFFF : rnd64());
    drain();
    check(tx == 1'b1, "idle_tx", tx, 1);
    check(busy == 1'b0, "idle_busy", busy, 0);
    check(row_idx == 3'd0, "idle_row", row_idx, 0);

    // Start held across done: two transfers back-to-back.
    for (int i = 0; i < 80 * C + 4; i++) step(1'b1, rnd64());
    drain();

    // Reset mid-transfer, then a fresh transfer of 0xFF in row 0.
    step(1'b1, rnd64());
    for (int i = 1; i < 150; i++) step(1'b0, rnd64());
    #3;
    reset = 1'b1;
    epoch++;
    exp_bytes.delete();
    exp_done.delete();
    next_free = 0;
    #1;
    check(tx == 1'b1, "midrst_tx", tx, 1);
    check(busy == 1'b0, "midrst_busy", busy, 0);
    check(done == 1'b0, "midrst_done", done, 0);
    check(row_idx == 3'd0, "midrst_row", row_idx, 0);
    for (int i = 0; i < 50; i++) begin
      step(1'b0, rnd64());
      if (i % 10 == 5) check(tx == 1'b1, "inrst_tx", tx, 1);
    end
    @(negedge clk) reset = 1'b0;
    step(1'b1, 64'h0000_0000_0000_00FF);
    drain();

    // Random grids and sporadic starts.
    for (int i = 0; i < 1600; i++) step($urandom_range(0, 40) == 0, rnd64());
    drain();

    check(exp_bytes.size() == 0, "bytes_left", exp_bytes.size(), 0);
    check(exp_done.size() == 0, "dones_left", exp_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
